// File: rtl/mem_write_responder.sv
// Memory-side line-write responder: captures one client line per mem_req/mem_ack
// handshake and drains it into a narrower SRAM write port, tracking burst length.
module mem_write_responder #(
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int ADDR_WIDTH        = 19,
    parameter int SRAM_WORDS        = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  mem_req,
    input  logic [ADDR_WIDTH-1:0]                 mem_start_addr,
    input  logic [ADDR_WIDTH-1:0]                 mem_size_bytes,
    input  logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] mem_data,
    input  logic                                  last,
    input  logic [$clog2(NUM_WORDS_IN_LINE)-1:0]  mem_last_valid,
    output logic                                  mem_ack,
    output logic                                  sram_we,
    output logic [ADDR_WIDTH-1:0]                 sram_addr,
    output logic [SRAM_WORDS*WORD_WIDTH-1:0]      sram_wdata,
    output logic [SRAM_WORDS-1:0]                 sram_be,
    input  logic                                  sram_ready,
    output logic                                  burst_done,
    output logic                                  size_err
);

    localparam int LVW    = $clog2(NUM_WORDS_IN_LINE);
    localparam int VW     = LVW + 1;
    localparam int NBEATS = NUM_WORDS_IN_LINE / SRAM_WORDS;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LW     = NUM_WORDS_IN_LINE * WORD_WIDTH;
    localparam int SW     = SRAM_WORDS * WORD_WIDTH;
    localparam int SSH    = $clog2(SRAM_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                state_r, state_n;
    logic                  burst_active_r, burst_active_n;
    logic [ADDR_WIDTH-1:0] base_r, base_n;
    logic [ADDR_WIDTH-1:0] size_r, size_n;
    logic [ADDR_WIDTH-1:0] offset_r, offset_n;
    logic [ADDR_WIDTH-1:0] line_idx_r, line_idx_n;
    logic [BW-1:0]         beat_r, beat_n;
    logic [LW-1:0]         line_buf_r, line_buf_n;
    logic                  buf_last_r, buf_last_n;
    logic [VW-1:0]         valid_r, valid_n;
    logic                  size_err_r, size_err_n;

    logic [VW-1:0]         raw_valid_s;
    logic [ADDR_WIDTH-1:0] cur_size_s;
    logic [ADDR_WIDTH-1:0] cur_offset_s;
    logic [ADDR_WIDTH-1:0] remaining_s;
    logic                  clipped_s;
    logic [VW-1:0]         cap_valid_s;
    logic                  last_beat_s;
    logic [ADDR_WIDTH-1:0] end_offset_s;

    // A first line is measured against the incoming size; continuation lines against the latched one.
    assign raw_valid_s  = last ? (VW'(mem_last_valid) + VW'(1'b1)) : VW'(NUM_WORDS_IN_LINE);
    assign cur_size_s   = burst_active_r ? size_r : mem_size_bytes;
    assign cur_offset_s = burst_active_r ? offset_r : {ADDR_WIDTH{1'b0}};
    assign remaining_s  = cur_size_s - cur_offset_s;
    assign clipped_s    = ADDR_WIDTH'(raw_valid_s) > remaining_s;
    assign cap_valid_s  = clipped_s ? VW'(remaining_s) : raw_valid_s;
    assign last_beat_s  = ((int'(beat_r) + 1) * SRAM_WORDS) >= int'(valid_r);
    assign end_offset_s = offset_r + ADDR_WIDTH'(valid_r);

    // Next-state and next-datapath computation for the IDLE/WRITE/ACK controller.
    always_comb begin
        state_n        = state_r;
        burst_active_n = burst_active_r;
        base_n         = base_r;
        size_n         = size_r;
        offset_n       = offset_r;
        line_idx_n     = line_idx_r;
        beat_n         = beat_r;
        line_buf_n     = line_buf_r;
        buf_last_n     = buf_last_r;
        valid_n        = valid_r;
        size_err_n     = size_err_r;
        case (state_r)
            IDLE: begin
                if (mem_req) begin
                    line_buf_n     = mem_data;
                    buf_last_n     = last;
                    valid_n        = cap_valid_s;
                    beat_n         = {BW{1'b0}};
                    burst_active_n = 1'b1;
                    if (!burst_active_r) begin
                        base_n     = mem_start_addr;
                        size_n     = mem_size_bytes;
                        offset_n   = {ADDR_WIDTH{1'b0}};
                        line_idx_n = {ADDR_WIDTH{1'b0}};
                        size_err_n = clipped_s;
                    end else begin
                        size_err_n = size_err_r | clipped_s;
                    end
                    if (cap_valid_s == {VW{1'b0}}) begin
                        state_n = ACK;
                    end else begin
                        state_n = WRITE;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            WRITE: begin
                if (sram_ready) begin
                    if (last_beat_s) begin
                        state_n = ACK;
                    end else begin
                        beat_n = beat_r + BW'(1'b1);
                    end
                end else begin
                    state_n = WRITE;
                end
            end
            ACK: begin
                offset_n   = end_offset_s;
                line_idx_n = line_idx_r + ADDR_WIDTH'(1'b1);
                state_n    = IDLE;
                if (buf_last_r) begin
                    burst_active_n = 1'b0;
                    size_err_n     = size_err_r | (end_offset_s != size_r);
                end else begin
                    burst_active_n = burst_active_r;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any buffered line and aborts the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            burst_active_r <= 1'b0;
            base_r         <= {ADDR_WIDTH{1'b0}};
            size_r         <= {ADDR_WIDTH{1'b0}};
            offset_r       <= {ADDR_WIDTH{1'b0}};
            line_idx_r     <= {ADDR_WIDTH{1'b0}};
            beat_r         <= {BW{1'b0}};
            line_buf_r     <= {LW{1'b0}};
            buf_last_r     <= 1'b0;
            valid_r        <= {VW{1'b0}};
            size_err_r     <= 1'b0;
        end else begin
            state_r        <= state_n;
            burst_active_r <= burst_active_n;
            base_r         <= base_n;
            size_r         <= size_n;
            offset_r       <= offset_n;
            line_idx_r     <= line_idx_n;
            beat_r         <= beat_n;
            line_buf_r     <= line_buf_n;
            buf_last_r     <= buf_last_n;
            valid_r        <= valid_n;
            size_err_r     <= size_err_n;
        end
    end

    // Output decode purely from registered state, so beats hold steady under backpressure.
    always_comb begin
        mem_ack    = 1'b0;
        burst_done = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = {ADDR_WIDTH{1'b0}};
        sram_wdata = {SW{1'b0}};
        sram_be    = {SRAM_WORDS{1'b0}};
        size_err   = size_err_r;
        if (state_r == WRITE) begin
            sram_we    = 1'b1;
            sram_addr  = base_r + (line_idx_r << LVW) + (ADDR_WIDTH'(beat_r) << SSH);
            sram_wdata = line_buf_r[int'(beat_r)*SW +: SW];
            for (int i = 0; i < SRAM_WORDS; i++) begin
                sram_be[i] = (int'(beat_r) * SRAM_WORDS + i) < int'(valid_r);
            end
        end else begin
            mem_ack    = (state_r == ACK);
            burst_done = (state_r == ACK) && buf_last_r;
        end
    end

endmodule
